change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_if.sv | 33 +++
 rtl/change_dispenser.sv | 134 +++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// Change-dispenser bus: request/refill handshake in, coin pulses, completion and inventory out.
interface change_dispenser_if #(
    parameter int INV_W = 6
) ();
    logic             change_valid;
    logic [8:0]       change_amount;
    logic             change_ready;
    logic             refill_valid;
    logic [INV_W-1:0] refill_q;
    logic [INV_W-1:0] refill_d;
    logic [INV_W-1:0] refill_n;
    logic             quarter_out;
    logic             dime_out;
    logic             nickel_out;
    logic             done;
    logic [8:0]       shortfall;
    logic             err;
    logic [INV_W-1:0] inv_q;
    logic [INV_W-1:0] inv_d;
    logic [INV_W-1:0] inv_n;

    modport master (
        output change_valid, change_amount, refill_valid, refill_q, refill_d, refill_n,
        input  change_ready, quarter_out, dime_out, nickel_out, done, shortfall, err,
               inv_q, inv_d, inv_n
    );

    modport slave (
        input  change_valid, change_amount, refill_valid, refill_q, refill_d, refill_n,
        output change_ready, quarter_out, dime_out, nickel_out, done, shortfall, err,
               inv_q, inv_d, inv_n
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays a cent amount in quarters/dimes/nickels from a
// finite inventory, one coin pulse every 3 cycles, and reports any unpaid residue.
module change_dispenser #(
    parameter int INV_W  = 6,
    parameter int INIT_Q = 20,
    parameter int INIT_D = 20,
    parameter int INIT_N = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    change_dispenser_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    // Coin index into the inventory array: 0 = quarter, 1 = dime, 2 = nickel.
    localparam logic [1:0] C_Q = 2'd0;
    localparam logic [1:0] C_D = 2'd1;
    localparam logic [1:0] C_N = 2'd2;

    state_t                      state_q, state_d;
    logic [8:0]                  rem_q, rem_d;
    logic [1:0]                  coin_q, coin_d;
    logic [2:0][INV_W-1:0]       inv_q, inv_d;
    logic                        pick_ok;
    logic [1:0]                  pick;

    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                 input logic [INV_W-1:0] b);
        logic [INV_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[INV_W] ? '1 : s[INV_W-1:0];
    endfunction

    function automatic logic [8:0] coin_value(input logic [1:0] c);
        case (c)
            C_Q:     return 9'd25;
            C_D:     return 9'd10;
            default: return 9'd5;
        endcase
    endfunction

    // Largest coin that fits the remaining amount and is still in stock.
    always_comb begin
        pick_ok = 1'b0;
        pick    = C_Q;
        if (rem_q >= 9'd25 && inv_q[C_Q] != '0) begin
            pick_ok = 1'b1;
            pick    = C_Q;
        end else if (rem_q >= 9'd10 && inv_q[C_D] != '0) begin
            pick_ok = 1'b1;
            pick    = C_D;
        end else if (rem_q >= 9'd5 && inv_q[C_N] != '0) begin
            pick_ok = 1'b1;
            pick    = C_N;
        end
    end

    // FSM state register; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: SELECT ends the request when nothing more can be paid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.change_valid) state_d = SELECT;
            SELECT:  state_d = pick_ok ? PULSE : DONE;
            PULSE:   state_d = GAP;
            GAP:     state_d = SELECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: Moore decode of state plus the latched coin choice.
    always_comb begin
        bus.change_ready = (state_q == IDLE);
        bus.quarter_out  = (state_q == PULSE) && (coin_q == C_Q);
        bus.dime_out     = (state_q == PULSE) && (coin_q == C_D);
        bus.nickel_out   = (state_q == PULSE) && (coin_q == C_N);
        bus.done         = (state_q == DONE);
        bus.shortfall    = (state_q == DONE) ? rem_q : 9'd0;
        bus.err          = (state_q == DONE) && (rem_q != 9'd0);
        bus.inv_q        = inv_q[C_Q];
        bus.inv_d        = inv_q[C_D];
        bus.inv_n        = inv_q[C_N];
    end

    // Datapath next-state: latch amount and refill in IDLE, pay one coin per PULSE.
    // Refill lands at the handshake edge, so the first SELECT already sees it.
    always_comb begin
        rem_d  = rem_q;
        coin_d = coin_q;
        inv_d  = inv_q;
        case (state_q)
            IDLE: begin
                if (bus.change_valid) rem_d = bus.change_amount;
                if (bus.refill_valid) begin
                    inv_d[C_Q] = sat_add(inv_q[C_Q], bus.refill_q);
                    inv_d[C_D] = sat_add(inv_q[C_D], bus.refill_d);
                    inv_d[C_N] = sat_add(inv_q[C_N], bus.refill_n);
                end
            end
            SELECT: if (pick_ok) coin_d = pick;
            PULSE: begin
                // Selection guarantees coin <= remaining and stock > 0.
                rem_d = rem_q - coin_value(coin_q);
                case (coin_q)
                    C_Q:     inv_d[C_Q] = inv_q[C_Q] - 1'b1;
                    C_D:     inv_d[C_D] = inv_q[C_D] - 1'b1;
                    default: inv_d[C_N] = inv_q[C_N] - 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers; inventory returns to its initial stock on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= 9'd0;
            coin_q     <= C_Q;
            inv_q[C_Q] <= INV_W'(INIT_Q);
            inv_q[C_D] <= INV_W'(INIT_D);
            inv_q[C_N] <= INV_W'(INIT_N);
        end else begin
            rem_q  <= rem_d;
            coin_q <= coin_d;
            inv_q  <= inv_d;
        end
    end
endmodule
